// File: rtl/dreg_shift_ctrl_if.sv
// Start handshake plus register-chain control bundle for dreg_shift_ctrl.
// master = requester (start/mode/stall/abort); slave = the controller.
interface dreg_shift_ctrl_if #(
  parameter int CNT_W = 10
);
  logic             dreg_shift_ctrl_iport_start_valid;
  logic             dreg_shift_ctrl_iport_mode;
  logic             dreg_shift_ctrl_oport_start_ready;
  logic             dreg_shift_ctrl_iport_stall;
  logic             dreg_shift_ctrl_iport_abort;
  logic             dreg_shift_ctrl_oport_en;
  logic             dreg_shift_ctrl_oport_sp;
  logic             dreg_shift_ctrl_oport_busy;
  logic [CNT_W-1:0] dreg_shift_ctrl_oport_cnt;
  logic             dreg_shift_ctrl_oport_done;
  logic             dreg_shift_ctrl_oport_aborted;

  modport master (
    output dreg_shift_ctrl_iport_start_valid,
    output dreg_shift_ctrl_iport_mode,
    output dreg_shift_ctrl_iport_stall,
    output dreg_shift_ctrl_iport_abort,
    input  dreg_shift_ctrl_oport_start_ready,
    input  dreg_shift_ctrl_oport_en,
    input  dreg_shift_ctrl_oport_sp,
    input  dreg_shift_ctrl_oport_busy,
    input  dreg_shift_ctrl_oport_cnt,
    input  dreg_shift_ctrl_oport_done,
    input  dreg_shift_ctrl_oport_aborted
  );

  modport slave (
    input  dreg_shift_ctrl_iport_start_valid,
    input  dreg_shift_ctrl_iport_mode,
    input  dreg_shift_ctrl_iport_stall,
    input  dreg_shift_ctrl_iport_abort,
    output dreg_shift_ctrl_oport_start_ready,
    output dreg_shift_ctrl_oport_en,
    output dreg_shift_ctrl_oport_sp,
    output dreg_shift_ctrl_oport_busy,
    output dreg_shift_ctrl_oport_cnt,
    output dreg_shift_ctrl_oport_done,
    output dreg_shift_ctrl_oport_aborted
  );
endinterface

// File: rtl/dreg_shift_ctrl.sv
// Load/shift sequencer for the D-register chain; DREG_SHIFT_CTRL_BACK2BACK_EN lets DONE accept a start.
// Tx start->done SIZE+2 cycles, Rx SIZE+1, +1 per stall; start_ready only when a start can be taken.
module dreg_shift_ctrl #(
  parameter int SIZE  = 512,
  parameter int CNT_W = 10
) (
  input logic               dreg_shift_ctrl_cport_clk,
  input logic               dreg_shift_ctrl_cport_rst,
  dreg_shift_ctrl_if.slave  ctl_if
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SIZE - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             aborted_q, aborted_d;

  logic start_valid, mode, stall, abort;
  logic start_ready, en, sp, busy, done;

  assign start_valid = ctl_if.dreg_shift_ctrl_iport_start_valid;
  assign mode        = ctl_if.dreg_shift_ctrl_iport_mode;
  assign stall       = ctl_if.dreg_shift_ctrl_iport_stall;
  assign abort       = ctl_if.dreg_shift_ctrl_iport_abort;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    aborted_d   = 1'b0;
    start_ready = 1'b0;
    en          = 1'b0;
    sp          = 1'b1;
    busy        = 1'b0;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          cnt_d   = '0;
          state_d = mode ? S_SHIFT : S_LOAD;
        end
      end

      S_LOAD: begin
        busy = 1'b1;
        sp   = 1'b0;
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          en      = 1'b1;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        busy = 1'b1;
        // abort outranks stall; either one keeps the chain frozen this cycle
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_IDLE;
        end else if (!stall) begin
          en    = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
`ifdef DREG_SHIFT_CTRL_BACK2BACK_EN
        start_ready = 1'b1;
        if (start_valid) begin
          cnt_d   = '0;
          state_d = mode ? S_SHIFT : S_LOAD;
        end
`endif
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge dreg_shift_ctrl_cport_clk or posedge dreg_shift_ctrl_cport_rst) begin
    if (dreg_shift_ctrl_cport_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      aborted_q <= aborted_d;
    end
  end

  assign ctl_if.dreg_shift_ctrl_oport_start_ready = start_ready;
  assign ctl_if.dreg_shift_ctrl_oport_en          = en;
  assign ctl_if.dreg_shift_ctrl_oport_sp          = sp;
  assign ctl_if.dreg_shift_ctrl_oport_busy        = busy;
  assign ctl_if.dreg_shift_ctrl_oport_cnt         = cnt_q;
  assign ctl_if.dreg_shift_ctrl_oport_done        = done;
  assign ctl_if.dreg_shift_ctrl_oport_aborted     = aborted_q;

endmodule

// File: tb/tb_dreg_shift_ctrl.sv
// Directed bench for dreg_shift_ctrl at SIZE = 8: per-cycle vector table plus latency/abort/reset/back-to-back sequences.
module tb_dreg_shift_ctrl;
  localparam int SIZE  = 8;
  localparam int CNT_W = 4;
`ifdef DREG_SHIFT_CTRL_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif
  localparam bit H = 1'b1;
  localparam bit L = 1'b0;
  localparam int NV = 22;

  typedef struct {
    bit sv, md, st, ab;
    bit en, sp, busy, rdy, done, abt;
    int cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;
  vec_t tbl[NV];

  dreg_shift_ctrl_if #(.CNT_W(CNT_W)) bus ();

  dreg_shift_ctrl #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
    .dreg_shift_ctrl_cport_clk (clk),
    .dreg_shift_ctrl_cport_rst (rst),
    .ctl_if                    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive(input bit sv, input bit md, input bit st, input bit ab);
    bus.dreg_shift_ctrl_iport_start_valid = sv;
    bus.dreg_shift_ctrl_iport_mode        = md;
    bus.dreg_shift_ctrl_iport_stall       = st;
    bus.dreg_shift_ctrl_iport_abort       = ab;
  endtask

  // Counts falling edges after the current one until done is seen; n = -1 on timeout.
  task automatic wait_done(input bit sv, input bit md, output int n, output bit sp_low);
    n = -1;
    sp_low = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      drive(sv, md, 1'b0, 1'b0);
      #1;
      if (!bus.dreg_shift_ctrl_oport_sp) sp_low = 1'b1;
      if (bus.dreg_shift_ctrl_oport_done) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic wait_cnt(input int target, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      if (bus.dreg_shift_ctrl_oport_busy && int'(bus.dreg_shift_ctrl_oport_cnt) == target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int  n;
    bit  sp_low, ok, pulse_seen;

    // one transmit with 3 stalls after the 4th shift, then a receive aborted (with stall) at cnt 3
    tbl[0] = '{H,L,L,L, L,H,L,H,L,L, 0};
    tbl[1] = '{L,L,L,L, H,L,H,L,L,L, 0};
    for (int k = 0; k < 4; k++) tbl[2+k] = '{L,L,L,L, H,H,H,L,L,L, k};
    for (int k = 0; k < 3; k++) tbl[6+k] = '{L,L,H,L, L,H,H,L,L,L, 4};
    for (int k = 0; k < 4; k++) tbl[9+k] = '{L,L,L,L, H,H,H,L,L,L, 4+k};
    tbl[13] = '{L,L,L,L, L,H,L,B2B,H,L, 8};
    tbl[14] = '{H,H,L,L, L,H,L,H,L,L, 8};
    tbl[15] = '{L,L,L,L, H,H,H,L,L,L, 0};
    tbl[16] = '{H,L,L,L, H,H,H,L,L,L, 1};
    tbl[17] = '{L,L,L,L, H,H,H,L,L,L, 2};
    tbl[18] = '{L,L,H,H, L,H,H,L,L,L, 3};
    tbl[19] = '{L,L,L,L, L,H,L,H,L,H, 3};
    tbl[20] = '{L,L,L,H, L,H,L,H,L,L, 3};
    tbl[21] = '{L,L,L,L, L,H,L,H,L,L, 3};

    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst.en",   int'(bus.dreg_shift_ctrl_oport_en), 0);
    chk("rst.sp",   int'(bus.dreg_shift_ctrl_oport_sp), 1);
    chk("rst.busy", int'(bus.dreg_shift_ctrl_oport_busy), 0);
    chk("rst.cnt",  int'(bus.dreg_shift_ctrl_oport_cnt), 0);
    chk("rst.rdy",  int'(bus.dreg_shift_ctrl_oport_start_ready), 1);
    chk("rst.done", int'(bus.dreg_shift_ctrl_oport_done), 0);
    chk("rst.abt",  int'(bus.dreg_shift_ctrl_oport_aborted), 0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i].sv, tbl[i].md, tbl[i].st, tbl[i].ab);
      #1;
      chk($sformatf("v%0d.en", i),   int'(bus.dreg_shift_ctrl_oport_en), int'(tbl[i].en));
      chk($sformatf("v%0d.sp", i),   int'(bus.dreg_shift_ctrl_oport_sp), int'(tbl[i].sp));
      chk($sformatf("v%0d.busy", i), int'(bus.dreg_shift_ctrl_oport_busy), int'(tbl[i].busy));
      chk($sformatf("v%0d.rdy", i),  int'(bus.dreg_shift_ctrl_oport_start_ready), int'(tbl[i].rdy));
      chk($sformatf("v%0d.done", i), int'(bus.dreg_shift_ctrl_oport_done), int'(tbl[i].done));
      chk($sformatf("v%0d.abt", i),  int'(bus.dreg_shift_ctrl_oport_aborted), int'(tbl[i].abt));
      chk($sformatf("v%0d.cnt", i),  int'(bus.dreg_shift_ctrl_oport_cnt), tbl[i].cnt);
    end

    // transmit latency
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    wait_done(1'b0, 1'b0, n, sp_low);
    chk("tx.latency", n, SIZE + 2);
    chk("tx.cnt", int'(bus.dreg_shift_ctrl_oport_cnt), SIZE);
    chk("tx.sp_low", int'(sp_low), 1);

    // receive latency, sp never drops; abort in DONE is ignored
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    wait_done(1'b0, 1'b0, n, sp_low);
    chk("rx.latency", n, SIZE + 1);
    chk("rx.sp_low", int'(sp_low), 0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("done_abort.done", int'(bus.dreg_shift_ctrl_oport_done), 1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("done_abort.abt", int'(bus.dreg_shift_ctrl_oport_aborted), 0);
    chk("done_abort.cnt", int'(bus.dreg_shift_ctrl_oport_cnt), SIZE);

    // transmit aborted at cnt 5
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    wait_cnt(5, ok);
    chk("abort.reach5", int'(ok), 1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("abort.en", int'(bus.dreg_shift_ctrl_oport_en), 0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("abort.abt",  int'(bus.dreg_shift_ctrl_oport_aborted), 1);
    chk("abort.done", int'(bus.dreg_shift_ctrl_oport_done), 0);
    chk("abort.cnt",  int'(bus.dreg_shift_ctrl_oport_cnt), 5);
    chk("abort.rdy",  int'(bus.dreg_shift_ctrl_oport_start_ready), 1);
    @(negedge clk);
    #1;
    chk("abort.abt_once", int'(bus.dreg_shift_ctrl_oport_aborted), 0);

    // asynchronous reset mid-shift at cnt 3
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    wait_cnt(3, ok);
    chk("rstmid.reach3", int'(ok), 1);
    #1 rst = 1'b1;
    #1;
    chk("rstmid.en",   int'(bus.dreg_shift_ctrl_oport_en), 0);
    chk("rstmid.busy", int'(bus.dreg_shift_ctrl_oport_busy), 0);
    chk("rstmid.cnt",  int'(bus.dreg_shift_ctrl_oport_cnt), 0);
    chk("rstmid.sp",   int'(bus.dreg_shift_ctrl_oport_sp), 1);
    pulse_seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 1) rst = 1'b0;
      #1;
      if (bus.dreg_shift_ctrl_oport_done || bus.dreg_shift_ctrl_oport_aborted) pulse_seen = 1'b1;
    end
    chk("rstmid.no_pulse", int'(pulse_seen), 0);

    // start_valid held high: spacing between consecutive done pulses
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    wait_done(1'b1, 1'b0, n, sp_low);
    chk("b2b.first", n, SIZE + 2);
    wait_done(1'b1, 1'b0, n, sp_low);
    chk("b2b.spacing", n, B2B ? SIZE + 2 : SIZE + 3);
    for (int k = 0; k < SIZE + 4; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
    end
    #1;
    chk("b2b.drain_busy", int'(bus.dreg_shift_ctrl_oport_busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
